// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bus bit positions, MEM stage states and error bits.
package pipe_pkg;

    localparam int WB_REGWRITE  = 1;
    localparam int WB_MEMTOREG  = 0;
    localparam int M_MEMREAD    = 1;
    localparam int M_MEMWRITE   = 0;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_TIMEOUT  = 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Wait-cycle counter for an outstanding memory access; expire flags the last allowed cycle.
module mem_timeout_cnt #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage fused with the MEM/WB register; drives a req/ack data memory and stalls upstream.
module mem_stage
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 200,
    parameter int CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  WB_i,
    input  logic [1:0]  M_i,
    input  logic [31:0] DMaddr_i,
    input  logic [31:0] DMdata_i,
    input  logic [4:0]  RDaddr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic [1:0]  WB_o,
    output logic [31:0] MemData_o,
    output logic [31:0] ALUres_o,
    output logic [4:0]  RDaddr_o,
    output logic [1:0]  err_o
);

    mem_state_t  state, state_next;
    logic [1:0]  wb_lat;
    logic [4:0]  rd_lat;
    logic [31:0] addr_lat;

    logic access, misaligned, expire;
    logic cnt_clr, cnt_en;
    logic do_pass, do_misalign, do_issue, do_wait, do_timeout, do_complete;

    assign access     = M_i[M_MEMREAD] | M_i[M_MEMWRITE];
    assign misaligned = (DMaddr_i[1:0] != 2'b00);

    mem_timeout_cnt #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .expire (expire)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ack takes priority over expiry so a response on the last allowed cycle still completes.
    always_comb begin
        state_next  = state;
        stall_o     = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        do_pass     = 1'b0;
        do_misalign = 1'b0;
        do_issue    = 1'b0;
        do_wait     = 1'b0;
        do_timeout  = 1'b0;
        do_complete = 1'b0;
        case (state)
            IDLE: begin
                if (!access) begin
                    do_pass = 1'b1;
                end else if (misaligned) begin
                    do_misalign = 1'b1;
                end else begin
                    do_issue   = 1'b1;
                    stall_o    = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    do_complete = 1'b1;
                    state_next  = IDLE;
                end else if (expire) begin
                    do_timeout = 1'b1;
                    state_next = IDLE;
                end else begin
                    do_wait = 1'b1;
                    stall_o = 1'b1;
                    cnt_en  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            WB_o        <= '0;
            MemData_o   <= '0;
            ALUres_o    <= '0;
            RDaddr_o    <= '0;
            err_o       <= '0;
            wb_lat      <= '0;
            rd_lat      <= '0;
            addr_lat    <= '0;
        end else if (do_pass) begin
            WB_o      <= WB_i;
            ALUres_o  <= DMaddr_i;
            RDaddr_o  <= RDaddr_i;
            MemData_o <= '0;
        end else if (do_misalign) begin
            err_o[ERR_MISALIGN] <= 1'b1;
            WB_o      <= '0;
            RDaddr_o  <= '0;
            ALUres_o  <= DMaddr_i;
            MemData_o <= '0;
        end else if (do_issue) begin
            wb_lat      <= WB_i;
            rd_lat      <= RDaddr_i;
            addr_lat    <= DMaddr_i;
            mem_req_o   <= 1'b1;
            mem_we_o    <= M_i[M_MEMWRITE];
            mem_addr_o  <= DMaddr_i;
            mem_wdata_o <= DMdata_i;
            WB_o        <= '0;
        end else if (do_wait) begin
            WB_o <= '0;
        end else if (do_timeout) begin
            mem_req_o          <= 1'b0;
            err_o[ERR_TIMEOUT] <= 1'b1;
            WB_o               <= '0;
        end else if (do_complete) begin
            mem_req_o <= 1'b0;
            WB_o      <= wb_lat;
            RDaddr_o  <= rd_lat;
            ALUres_o  <= addr_lat;
            MemData_o <= mem_we_o ? 32'h0 : mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized transactions against a cycle-count model.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  WB_i = '0;
    logic [1:0]  M_i = '0;
    logic [31:0] DMaddr_i = '0;
    logic [31:0] DMdata_i = '0;
    logic [4:0]  RDaddr_i = '0;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        stall_o;
    logic [1:0]  WB_o;
    logic [31:0] MemData_o, ALUres_o;
    logic [4:0]  RDaddr_o;
    logic [1:0]  err_o;

    int checks = 0;
    int errors = 0;

    mem_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .WB_i(WB_i), .M_i(M_i),
        .DMaddr_i(DMaddr_i), .DMdata_i(DMdata_i), .RDaddr_i(RDaddr_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .WB_o(WB_o), .MemData_o(MemData_o), .ALUres_o(ALUres_o),
        .RDaddr_o(RDaddr_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference expectations
    logic [1:0]  model_err;
    logic [1:0]  exp_wb;
    logic [31:0] exp_alu, exp_md;
    logic [4:0]  exp_rd;
    int          exp_stalls, exp_req_cycles;
    bit          chk_rd, chk_alu, chk_md;

    // Observations captured while driving a transaction
    int          obs_stalls, obs_req_cycles, obs_field_changes;
    logic        obs_we, obs_req_after;
    logic [31:0] obs_addr, obs_wdata;
    logic [1:0]  obs_wb, obs_err;
    logic [31:0] obs_alu, obs_md;
    logic [4:0]  obs_rd;

    // A transaction is judged by its architectural outcome: how many cycles upstream is held,
    // how many cycles the request is visible, and what reaches WB.
    task automatic model_txn(input logic [1:0] wb, input logic [1:0] m, input logic [31:0] addr,
                             input logic [4:0] rd, input int ack_dly, input logic [31:0] rdata);
        exp_stalls = 0; exp_req_cycles = 0; exp_md = '0; exp_alu = '0; exp_rd = '0; exp_wb = '0;
        chk_rd = 1; chk_alu = 1; chk_md = 1;
        if (m == 2'b00) begin
            exp_wb = wb; exp_alu = addr; exp_rd = rd;
        end else if (addr[1:0] != 2'b00) begin
            model_err[0] = 1'b1;
            chk_alu = 0; chk_md = 0;
        end else if (ack_dly < TO) begin
            exp_wb = wb; exp_rd = rd; exp_alu = addr;
            exp_md = m[0] ? 32'h0 : rdata;
            exp_stalls = ack_dly + 1; exp_req_cycles = ack_dly + 1;
        end else begin
            model_err[1] = 1'b1;
            chk_rd = 0; chk_alu = 0; chk_md = 0;
            exp_stalls = TO; exp_req_cycles = TO;
        end
    endtask

    // Drives one transaction; ack_dly is the number of BUSY cycles before the ack (>= TO means none).
    task automatic drive_txn(input logic [1:0] wb, input logic [1:0] m, input logic [31:0] addr,
                             input logic [31:0] data, input logic [4:0] rd, input int ack_dly,
                             input logic [31:0] rdata);
        WB_i = wb; M_i = m; DMaddr_i = addr; DMdata_i = data; RDaddr_i = rd; mem_ack_i = 1'b0;
        obs_stalls = 0; obs_req_cycles = 0; obs_field_changes = 0;
        obs_we = 1'b0; obs_addr = '0; obs_wdata = '0;
        @(negedge clk_i);
        if (stall_o) obs_stalls++;
        @(posedge clk_i); #1;
        if (mem_req_o) begin
            obs_we = mem_we_o; obs_addr = mem_addr_o; obs_wdata = mem_wdata_o;
            for (int b = 0; b < TO + 4; b++) begin
                WB_i = 2'($urandom); M_i = 2'($urandom); DMaddr_i = $urandom;
                DMdata_i = $urandom; RDaddr_i = 5'($urandom);
                mem_ack_i   = (b == ack_dly);
                mem_rdata_i = (b == ack_dly) ? rdata : $urandom;
                @(negedge clk_i);
                if (stall_o) obs_stalls++;
                if (mem_req_o) obs_req_cycles++;
                if (mem_we_o !== obs_we || mem_addr_o !== obs_addr || mem_wdata_o !== obs_wdata)
                    obs_field_changes++;
                @(posedge clk_i); #1;
                mem_ack_i = 1'b0;
                if (!mem_req_o) break;
            end
        end
        obs_req_after = mem_req_o;
        obs_wb = WB_o; obs_alu = ALUres_o; obs_md = MemData_o; obs_rd = RDaddr_o; obs_err = err_o;
        WB_i = '0; M_i = '0; DMaddr_i = '0; DMdata_i = '0; RDaddr_i = '0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, WB_o, MemData_o, ALUres_o, RDaddr_o, err_o} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h wb=%b md=%h alu=%h rd=%0d err=%b, expected all zero",
                     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, WB_o, MemData_o, ALUres_o, RDaddr_o, err_o);
        end
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        model_err = '0;
    endtask

    task automatic test_reset_mid_busy();
        WB_i = 2'b11; M_i = 2'b10; DMaddr_i = 32'h80; RDaddr_i = 5'd7;
        @(posedge clk_i); #1;
        WB_i = '0; M_i = '0; DMaddr_i = '0; RDaddr_i = '0;
        checks++;
        if (mem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_req_issued: got %b expected 1", mem_req_o); end
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_async_drop: got %b expected 0", mem_req_o); end
        checks++;
        if ({WB_o, RDaddr_o, ALUres_o, err_o, stall_o} !== '0) begin
            errors++;
            $display("[TB] FAIL midrst_outputs: got wb=%b rd=%0d alu=%h err=%b stall=%b expected all zero",
                     WB_o, RDaddr_o, ALUres_o, err_o, stall_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        model_err = '0;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        checks++;
        if (WB_o !== 2'b00 || RDaddr_o !== 5'd0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_late_ack: got wb=%b rd=%0d req=%b expected wb=00 rd=0 req=0", WB_o, RDaddr_o, mem_req_o);
        end
    endtask

    task automatic test_passthrough();
        model_txn(2'b10, 2'b00, 32'h10, 5'd3, 0, '0);
        drive_txn(2'b10, 2'b00, 32'h10, 32'h55, 5'd3, 0, '0);
        checks++;
        if ({obs_wb, obs_alu, obs_rd} !== {exp_wb, exp_alu, exp_rd}) begin
            errors++;
            $display("[TB] FAIL pass_fixed: got wb=%b alu=%h rd=%0d expected wb=%b alu=%h rd=%0d",
                     obs_wb, obs_alu, obs_rd, exp_wb, exp_alu, exp_rd);
        end
        checks++;
        if (obs_stalls != 0 || obs_req_after !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pass_no_stall: got stalls=%0d req=%b expected 0 and 0", obs_stalls, obs_req_after);
        end
        for (int i = 0; i < 6; i++) begin
            logic [1:0]  wb;
            logic [31:0] addr;
            logic [4:0]  rd;
            wb = 2'($urandom); addr = $urandom; rd = 5'($urandom);
            model_txn(wb, 2'b00, addr, rd, 0, '0);
            drive_txn(wb, 2'b00, addr, $urandom, rd, 0, '0);
            checks++;
            if ({obs_wb, obs_alu, obs_rd, obs_md} !== {exp_wb, exp_alu, exp_rd, exp_md} || obs_stalls != 0) begin
                errors++;
                $display("[TB] FAIL pass_random: got wb=%b alu=%h rd=%0d md=%h stalls=%0d expected wb=%b alu=%h rd=%0d md=%h stalls=0",
                         obs_wb, obs_alu, obs_rd, obs_md, obs_stalls, exp_wb, exp_alu, exp_rd, exp_md);
            end
        end
    endtask

    task automatic test_load();
        model_txn(2'b11, 2'b10, 32'h40, 5'd9, 2, 32'hDEADBEEF);
        drive_txn(2'b11, 2'b10, 32'h40, 32'h0, 5'd9, 2, 32'hDEADBEEF);
        checks++;
        if (obs_stalls != exp_stalls) begin errors++; $display("[TB] FAIL load_stalls: got %0d expected %0d", obs_stalls, exp_stalls); end
        checks++;
        if (obs_we !== 1'b0 || obs_addr !== 32'h40 || obs_field_changes != 0) begin
            errors++;
            $display("[TB] FAIL load_request: got we=%b addr=%h changes=%0d expected we=0 addr=00000040 changes=0", obs_we, obs_addr, obs_field_changes);
        end
        checks++;
        if ({obs_md, obs_rd, obs_wb, obs_alu} !== {exp_md, exp_rd, exp_wb, exp_alu}) begin
            errors++;
            $display("[TB] FAIL load_result: got md=%h rd=%0d wb=%b alu=%h expected md=%h rd=%0d wb=%b alu=%h",
                     obs_md, obs_rd, obs_wb, obs_alu, exp_md, exp_rd, exp_wb, exp_alu);
        end
    endtask

    task automatic test_store();
        model_txn(2'b00, 2'b01, 32'h44, 5'd0, 0, 32'hFFFF0000);
        drive_txn(2'b00, 2'b01, 32'h44, 32'h12345678, 5'd0, 0, 32'hFFFF0000);
        checks++;
        if (obs_stalls != 1) begin errors++; $display("[TB] FAIL store_stalls: got %0d expected 1", obs_stalls); end
        checks++;
        if (obs_we !== 1'b1 || obs_wdata !== 32'h12345678 || obs_addr !== 32'h44) begin
            errors++;
            $display("[TB] FAIL store_request: got we=%b wdata=%h addr=%h expected we=1 wdata=12345678 addr=00000044", obs_we, obs_wdata, obs_addr);
        end
        checks++;
        if (obs_md !== exp_md || obs_req_after !== 1'b0) begin
            errors++;
            $display("[TB] FAIL store_result: got md=%h req=%b expected md=%h req=0", obs_md, obs_req_after, exp_md);
        end
    endtask

    task automatic test_misaligned();
        model_txn(2'b11, 2'b10, 32'h42, 5'd5, 0, '0);
        drive_txn(2'b11, 2'b10, 32'h42, 32'h0, 5'd5, 0, '0);
        checks++;
        if (obs_err !== model_err) begin errors++; $display("[TB] FAIL misalign_err: got %b expected %b", obs_err, model_err); end
        checks++;
        if (obs_wb !== exp_wb || obs_rd !== exp_rd) begin
            errors++;
            $display("[TB] FAIL misalign_bubble: got wb=%b rd=%0d expected wb=%b rd=%0d", obs_wb, obs_rd, exp_wb, exp_rd);
        end
        checks++;
        if (obs_stalls != 0 || obs_req_cycles != 0 || obs_req_after !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misalign_no_req: got stalls=%0d req_cycles=%0d req=%b expected 0 0 0", obs_stalls, obs_req_cycles, obs_req_after);
        end
    endtask

    task automatic test_timeout();
        model_txn(2'b10, 2'b10, 32'h100, 5'd4, TO + 100, '0);
        drive_txn(2'b10, 2'b10, 32'h100, 32'h0, 5'd4, TO + 100, '0);
        checks++;
        if (obs_req_cycles != exp_req_cycles || obs_req_after !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_req: got req_cycles=%0d req=%b expected %0d and 0", obs_req_cycles, obs_req_after, exp_req_cycles);
        end
        checks++;
        if (obs_err !== model_err) begin errors++; $display("[TB] FAIL timeout_err: got %b expected %b", obs_err, model_err); end
        checks++;
        if (obs_stalls != exp_stalls || obs_wb !== 2'b00) begin
            errors++;
            $display("[TB] FAIL timeout_stall: got stalls=%0d wb=%b expected %0d and 00", obs_stalls, obs_wb, exp_stalls);
        end
    endtask

    task automatic test_back_to_back();
        model_txn(2'b10, 2'b01, 32'h104, 5'd12, 1, '0);
        drive_txn(2'b10, 2'b01, 32'h104, 32'hA5A5A5A5, 5'd12, 1, '0);
        checks++;
        if (obs_stalls != exp_stalls || obs_we !== 1'b1 || obs_wdata !== 32'hA5A5A5A5) begin
            errors++;
            $display("[TB] FAIL b2b_accept: got stalls=%0d we=%b wdata=%h expected %0d 1 a5a5a5a5", obs_stalls, obs_we, obs_wdata, exp_stalls);
        end
        checks++;
        if ({obs_wb, obs_rd, obs_md, obs_alu} !== {exp_wb, exp_rd, exp_md, exp_alu}) begin
            errors++;
            $display("[TB] FAIL b2b_result: got wb=%b rd=%0d md=%h alu=%h expected wb=%b rd=%0d md=%h alu=%h",
                     obs_wb, obs_rd, obs_md, obs_alu, exp_wb, exp_rd, exp_md, exp_alu);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  wb, m;
            logic [31:0] addr, rdata;
            logic [4:0]  rd;
            int          dly;
            wb = 2'($urandom); m = 2'($urandom); rd = 5'($urandom); rdata = $urandom;
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            dly = $urandom_range(0, TO);
            model_txn(wb, m, addr, rd, dly, rdata);
            drive_txn(wb, m, addr, $urandom, rd, dly, rdata);
            checks++;
            if (obs_wb !== exp_wb || (chk_rd && obs_rd !== exp_rd) || (chk_alu && obs_alu !== exp_alu)
                || (chk_md && obs_md !== exp_md)) begin
                errors++;
                $display("[TB] FAIL random_result[%0d]: got wb=%b rd=%0d alu=%h md=%h expected wb=%b rd=%0d alu=%h md=%h",
                         i, obs_wb, obs_rd, obs_alu, obs_md, exp_wb, exp_rd, exp_alu, exp_md);
            end
            checks++;
            if (obs_stalls != exp_stalls || obs_req_cycles != exp_req_cycles || obs_req_after !== 1'b0
                || obs_field_changes != 0 || obs_err !== model_err) begin
                errors++;
                $display("[TB] FAIL random_timing[%0d]: got stalls=%0d req_cycles=%0d req=%b changes=%0d err=%b expected %0d %0d 0 0 %b",
                         i, obs_stalls, obs_req_cycles, obs_req_after, obs_field_changes, obs_err,
                         exp_stalls, exp_req_cycles, model_err);
            end
        end
    endtask

    initial begin
        model_err = '0;
        test_reset();
        test_reset_mid_busy();
        test_passthrough();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage, directly downstream of the EX/MEM register; fused with the MEM/WB pipeline register.
- Consumes EX/MEM control (WB, M), ALU result/address, store data and destination register.
- Performs data-memory reads and writes through a req/ack handshake to a multi-cycle memory, asserting stall_o while an access is outstanding.
- Registers the results for the WB stage.

Parameters:
- TIMEOUT, 200: BUSY cycles without ack before the access is aborted; must be < 2**CNT_W.
- CNT_W, 8: timeout counter width.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- WB_i  in  2  [1]=RegWrite, [0]=MemtoReg
- M_i  in  2  [1]=MemRead, [0]=MemWrite
- DMaddr_i  in  32  ALU result / data address
- DMdata_i  in  32  store data
- RDaddr_i  in  5  destination register
- mem_req_o  out  1  memory request, registered
- mem_we_o  out  1  1=write, 0=read; valid while mem_req_o=1
- mem_addr_o  out  32  word address; valid while mem_req_o=1
- mem_wdata_o  out  32  store data; valid while mem_req_o=1
- mem_ack_i  in  1  single-cycle completion pulse
- mem_rdata_i  in  32  read data; valid in the mem_ack_i cycle
- stall_o  out  1  holds PC, IF/ID, ID/EX and EX/MEM (hazard unit gates their enables)
- WB_o  out  2  to WB stage
- MemData_o  out  32  load data
- ALUres_o  out  32  registered DMaddr_i
- RDaddr_o  out  5  destination register
- err_o  out  2  sticky: [0]=misaligned access, [1]=timeout

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, counter=0.
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o = 0.
  - WB_o, MemData_o, ALUres_o, RDaddr_o, err_o = 0.
  - Reset mid-access drops mem_req_o immediately; any later mem_ack_i is ignored.
- access = M_i[1] | M_i[0]. If both bits are set, the access is treated as a write.
- States: IDLE, BUSY.
- IDLE, no access: 1-cycle pass-through. WB_o<=WB_i, ALUres_o<=DMaddr_i, RDaddr_o<=RDaddr_i, MemData_o<=0. stall_o=0.
- IDLE, access with DMaddr_i[1:0]!=0:
  - no request issued; err_o[0]<=1.
  - bubble loaded: WB_o<=0, RDaddr_o<=0.
  - stall_o=0.
- IDLE, aligned access:
  - stall_o=1 (combinational).
  - Latch WB_i, RDaddr_i, DMaddr_i internally.
  - mem_req_o<=1, mem_we_o<=M_i[0], mem_addr_o<=DMaddr_i, mem_wdata_o<=DMdata_i.
  - counter<=0; go to BUSY.
  - MEM/WB loads a bubble (WB_o<=0).
- BUSY, mem_ack_i=0:
  - stall_o=1; counter increments.
  - MEM/WB loads a bubble.
  - If counter==TIMEOUT-1: mem_req_o<=0, err_o[1]<=1, bubble, go to IDLE. stall_o=0 in that final cycle.
- BUSY, mem_ack_i=1:
  - stall_o=0 (combinational from ack), so upstream advances on this edge.
  - mem_req_o<=0.
  - WB_o<=latched WB, RDaddr_o<=latched RD, ALUres_o<=latched addr.
  - MemData_o<=mem_rdata_i for a read, 0 for a write.
  - Go to IDLE.
- mem_ack_i while mem_req_o=0 is ignored.
- Request fields stay constant while in BUSY.
- Latency:
  - non-access: 1 cycle.
  - access: ≥2 cycles in stage; minimum 1 stall cycle when ack arrives in the first BUSY cycle.
- err_o bits clear only on reset.
- Inputs sampled in BUSY are ignored; upstream is held by stall_o.

Decomposition:
- Shared package pipe_pkg:
  - WB/M bit-index constants (WB_REGWRITE=1, WB_MEMTOREG=0, M_MEMREAD=1, M_MEMWRITE=0).
  - State enum {IDLE, BUSY}.
  - ERR_MISALIGN=0, ERR_TIMEOUT=1.
- One sub-module, mem_timeout_cnt: counter with clear, enable and expire output, parameterised by CNT_W and TIMEOUT.

Test Plan:
- Reset mid-BUSY (assert rst_i with mem_req_o=1) -> mem_req_o=0 asynchronously; all outputs 0; a later ack produces no WB_o change.
- Non-access, WB_i=2'b10, DMaddr_i=0x10, RDaddr_i=3 -> next cycle WB_o=2'b10, ALUres_o=0x10, RDaddr_o=3, stall_o never 1.
- Load: M_i=2'b10, addr=0x40, ack 3 cycles after req with rdata=0xDEADBEEF -> stall_o high 3 cycles; then MemData_o=0xDEADBEEF, RDaddr_o latched, mem_we_o=0 throughout.
- Store: M_i=2'b01, addr=0x44, data=0x12345678, ack in first BUSY cycle -> mem_we_o=1, mem_wdata_o=0x12345678; stall_o high exactly 1 cycle; MemData_o=0.
- Misaligned load at addr=0x42 -> no mem_req_o; err_o=2'b01; WB_o=0; no stall.
- No ack with TIMEOUT=4 -> mem_req_o drops after 4 BUSY cycles; err_o[1]=1; stall released; back-to-back next access is accepted.
